// File: rtl/board_render_ctrl_pkg.sv
// Shared types, geometry and palette for the board renderer.
// Colours are packed {r[3:0], g[3:0], b[3:0]}.
package board_pkg;

    localparam int H_ACTIVE    = 1280;
    localparam int V_ACTIVE    = 800;
    localparam int BOARD_X0    = 384;
    localparam int BOARD_Y0    = 144;
    localparam int TILE_LOG2   = 6;
    localparam int TILE        = 1 << TILE_LOG2;
    localparam int BOARD_N     = 8;
    localparam int BOARD_PX    = BOARD_N * TILE;
    localparam int BOARD_CELLS = BOARD_N * BOARD_N;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2,
        RSVD  = 2'd3
    } piece_t;

    typedef enum logic [1:0] {
        SET_PIECE   = 2'd0,
        MOVE_CURSOR = 2'd1,
        CLEAR_BOARD = 2'd2,
        NOP         = 2'd3
    } cfg_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        COMMIT = 2'd2
    } ctrl_state_t;

    localparam logic [11:0] BG_C     = 12'h112;
    localparam logic [11:0] GRID_C   = 12'h444;
    localparam logic [11:0] LIGHT_C  = 12'hDCA;
    localparam logic [11:0] DARK_C   = 12'h852;
    localparam logic [11:0] RED_C    = 12'hE11;
    localparam logic [11:0] BLUE_C   = 12'h13E;
    localparam logic [11:0] CURSOR_C = 12'hFF0;

    // Board cells are stored row-major, eight cells per row.
    function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
        return {row, col};
    endfunction

endpackage

// File: rtl/board_render_ctrl_if.sv
// Board/cursor update handshake between game logic (master) and the renderer (slave).
interface board_render_ctrl_if;

    logic       cfg_req;
    logic [1:0] cfg_op;
    logic [2:0] cfg_tx;
    logic [2:0] cfg_ty;
    logic [1:0] cfg_piece;
    logic       cfg_ack;
    logic       cfg_busy;

    modport master (
        output cfg_req, cfg_op, cfg_tx, cfg_ty, cfg_piece,
        input  cfg_ack, cfg_busy
    );

    modport slave (
        input  cfg_req, cfg_op, cfg_tx, cfg_ty, cfg_piece,
        output cfg_ack, cfg_busy
    );

endinterface

// File: rtl/board_render_ctrl_pixel_pipe.sv
// Two-stage pixel pipeline: S1 locates the scan position on the board, S2 picks the colour.
// Reads only the live board/cursor so the picture changes on frame boundaries only.
module board_pixel_pipe
    import board_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [10:0]                  x_i,
    input  logic [9:0]                   y_i,
    input  logic [BOARD_CELLS-1:0][1:0]  live_i,
    input  logic [2:0]                   cur_col_i,
    input  logic [2:0]                   cur_row_i,
    input  logic                         cursor_show_i,
    output logic [11:0]                  pix_o
);

    logic                  active_d, active_q;
    logic                  in_board_d, in_board_q;
    logic [2:0]            col_d, col_q;
    logic [2:0]            row_d, row_q;
    logic [TILE_LOG2-1:0]  ox_d, ox_q;
    logic [TILE_LOG2-1:0]  oy_d, oy_q;
    logic [TILE_LOG2+2:0]  dx, dy;
    logic [11:0]           pix_d, pix_q;
    piece_t                piece;
    logic                  cur_tile, on_border, in_inset;

    // Offsets wrap outside the board; in_board (decided before the subtract) masks them.
    assign dx = (TILE_LOG2+3)'(x_i - 11'(BOARD_X0));
    assign dy = (TILE_LOG2+3)'({1'b0, y_i} - 11'(BOARD_Y0));

    assign active_d   = (x_i < 11'(H_ACTIVE)) && (y_i < 10'(V_ACTIVE));
    assign in_board_d = (x_i >= 11'(BOARD_X0)) && (x_i < 11'(BOARD_X0 + BOARD_PX)) &&
                        (y_i >= 10'(BOARD_Y0)) && (y_i < 10'(BOARD_Y0 + BOARD_PX));
    assign col_d      = dx[TILE_LOG2 +: 3];
    assign row_d      = dy[TILE_LOG2 +: 3];
    assign ox_d       = dx[TILE_LOG2-1:0];
    assign oy_d       = dy[TILE_LOG2-1:0];

    always_comb begin
        piece     = piece_t'(live_i[cell_idx(col_q, row_q)]);
        cur_tile  = in_board_q && (col_q == cur_col_i) && (row_q == cur_row_i);
        on_border = (ox_q < TILE_LOG2'(2)) || (ox_q >= TILE_LOG2'(TILE - 2)) ||
                    (oy_q < TILE_LOG2'(2)) || (oy_q >= TILE_LOG2'(TILE - 2));
        in_inset  = (ox_q >= TILE_LOG2'(8)) && (ox_q < TILE_LOG2'(TILE - 8)) &&
                    (oy_q >= TILE_LOG2'(8)) && (oy_q < TILE_LOG2'(TILE - 8));

        pix_d = BG_C;
        if (!active_q) begin
            pix_d = '0;
        end else if (cur_tile && on_border && cursor_show_i) begin
            pix_d = CURSOR_C;
        end else if (in_board_q && in_inset && (piece == RED)) begin
            pix_d = RED_C;
        end else if (in_board_q && in_inset && (piece == BLUE)) begin
            pix_d = BLUE_C;
        end else if (in_board_q && ((ox_q == '0) || (oy_q == '0))) begin
            pix_d = GRID_C;
        end else if (in_board_q) begin
            pix_d = (col_q[0] ^ row_q[0]) ? DARK_C : LIGHT_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            in_board_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            pix_q      <= '0;
        end else begin
            active_q   <= active_d;
            in_board_q <= in_board_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            pix_q      <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/board_render_ctrl.sv
// Board renderer top: update FSM, shadow/live board storage, frame counter, pixel pipe.
// Build option CURSOR_BLINK_EN: cursor border shown only while frame_cnt[5]==0.
//
// state  | meaning
// IDLE   | sample update requests; start COMMIT on vblank_start
// CLEAR  | wipe one shadow cell per cycle, index 0..63
// COMMIT | copy shadow board/cursor into live copy, count the frame
module board_render_ctrl
    import board_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [10:0]               curr_x_i,
    input  logic [9:0]                curr_y_i,
    board_render_ctrl_if.slave        cfg,
    output logic [15:0]               frame_cnt_o,
    output logic [3:0]                pix_r_o,
    output logic [3:0]                pix_g_o,
    output logic [3:0]                pix_b_o
);

    ctrl_state_t                   state_q, state_d;
    logic [5:0]                    clr_idx_q, clr_idx_d;
    logic                          commit_pend_q, commit_pend_d;
    logic                          ack_q, ack_d;
    logic                          busy;
    logic [15:0]                   frame_cnt_q, frame_cnt_d;
    logic [BOARD_CELLS-1:0][1:0]   shadow_q, shadow_d;
    logic [BOARD_CELLS-1:0][1:0]   live_q, live_d;
    logic [2:0]                    cur_sx_q, cur_sx_d, cur_sy_q, cur_sy_d;
    logic [2:0]                    cur_lx_q, cur_lx_d, cur_ly_q, cur_ly_d;
    logic                          vblank_start, req_take, cursor_show;
    logic [1:0]                    piece_wr;
    cfg_op_t                       op;
    logic [11:0]                   pix;

    assign vblank_start = (curr_x_i == '0) && (curr_y_i == 10'(V_ACTIVE));
    assign op           = cfg_op_t'(cfg.cfg_op);
    assign piece_wr     = (cfg.cfg_piece == RSVD) ? EMPTY : cfg.cfg_piece;
    // Holding off while ack is high spaces accepted requests at least two cycles apart.
    assign req_take     = (state_q == IDLE) && !vblank_start && cfg.cfg_req && !ack_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (vblank_start)                           state_d = COMMIT;
                else if (req_take && (op == CLEAR_BOARD))   state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_idx_q == 6'd63) state_d = (commit_pend_q || vblank_start) ? COMMIT : IDLE;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d         = 1'b0;
        busy          = 1'b0;
        clr_idx_d     = '0;
        commit_pend_d = 1'b0;
        shadow_d      = shadow_q;
        cur_sx_d      = cur_sx_q;
        cur_sy_d      = cur_sy_q;
        live_d        = live_q;
        cur_lx_d      = cur_lx_q;
        cur_ly_d      = cur_ly_q;
        frame_cnt_d   = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_take) begin
                    unique case (op)
                        SET_PIECE: begin
                            shadow_d[cell_idx(cfg.cfg_tx, cfg.cfg_ty)] = piece_wr;
                            ack_d = 1'b1;
                        end
                        MOVE_CURSOR: begin
                            cur_sx_d = cfg.cfg_tx;
                            cur_sy_d = cfg.cfg_ty;
                            ack_d    = 1'b1;
                        end
                        CLEAR_BOARD: ack_d = 1'b0;
                        default:     ack_d = 1'b1;
                    endcase
                end
            end
            CLEAR: begin
                busy                = 1'b1;
                shadow_d[clr_idx_q] = EMPTY;
                if (clr_idx_q == 6'd63) begin
                    ack_d = 1'b1;
                end else begin
                    clr_idx_d     = clr_idx_q + 6'd1;
                    commit_pend_d = commit_pend_q || vblank_start;
                end
            end
            COMMIT: begin
                busy        = 1'b1;
                live_d      = shadow_q;
                cur_lx_d    = cur_sx_q;
                cur_ly_d    = cur_sy_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx_q     <= '0;
            commit_pend_q <= 1'b0;
            ack_q         <= 1'b0;
            frame_cnt_q   <= '0;
            shadow_q      <= '0;
            live_q        <= '0;
            cur_sx_q      <= '0;
            cur_sy_q      <= '0;
            cur_lx_q      <= '0;
            cur_ly_q      <= '0;
        end else begin
            clr_idx_q     <= clr_idx_d;
            commit_pend_q <= commit_pend_d;
            ack_q         <= ack_d;
            frame_cnt_q   <= frame_cnt_d;
            shadow_q      <= shadow_d;
            live_q        <= live_d;
            cur_sx_q      <= cur_sx_d;
            cur_sy_q      <= cur_sy_d;
            cur_lx_q      <= cur_lx_d;
            cur_ly_q      <= cur_ly_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    assign cursor_show = ~frame_cnt_q[5];
`else
    assign cursor_show = 1'b1;
`endif

    board_pixel_pipe u_pipe (
        .clk           (clk),
        .rst           (rst),
        .x_i           (curr_x_i),
        .y_i           (curr_y_i),
        .live_i        (live_q),
        .cur_col_i     (cur_lx_q),
        .cur_row_i     (cur_ly_q),
        .cursor_show_i (cursor_show),
        .pix_o         (pix)
    );

    assign cfg.cfg_ack  = ack_q;
    assign cfg.cfg_busy = busy;
    assign frame_cnt_o  = frame_cnt_q;
    assign pix_r_o      = pix[11:8];
    assign pix_g_o      = pix[7:4];
    assign pix_b_o      = pix[3:0];

endmodule
